// File: rtl/pulse_stretch_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_pkg
// Shared types and constants for the multi-channel pulse stretcher.
//   state_t : per-channel FSM state (ST_IDLE, ST_ACTIVE)
//   CH_MAX  : largest supported channel count
// Optional feature macro used by the design files: PULSE_STRETCH_DONE_EN
// -----------------------------------------------------------------------------
package pulse_stretch_pkg;

  localparam int CH_MAX = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_stretch_ch.sv
// -----------------------------------------------------------------------------
// pulse_stretch_ch
// One pulse-stretcher channel: IDLE/ACTIVE FSM, W-bit counter, latched length
// and registered output level.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   trig_i       : single-cycle start request
//   len_i        : pulse length, sampled only when the trigger is accepted
//   dout_o       : ACT_LVL while active, ~ACT_LVL otherwise (registered)
//   done_o       : one-cycle strobe after a completed pulse
//                  (only with PULSE_STRETCH_DONE_EN defined)
//   state_nxt_o  : next FSM state, also serves as the state debug view
//
// Trigger semantics: there is no ready/back-pressure. A trigger is accepted on
// a rising edge when trig_i=1, len_i!=0 and the channel is IDLE (or ACTIVE with
// RETRIG=1); otherwise it is dropped silently.
// -----------------------------------------------------------------------------
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int   W       = 8,
  parameter int   RETRIG  = 0,
  parameter logic ACT_LVL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig_i,
  input  logic [W-1:0] len_i,
  output logic         dout_o,
`ifdef PULSE_STRETCH_DONE_EN
  output logic         done_o,
`endif
  output state_t       state_nxt_o
);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] len_q, len_d;
  logic         dout_q, dout_d;
  logic         accept;
`ifdef PULSE_STRETCH_DONE_EN
  logic         done_q, done_d;
`endif

  // Acceptance outranks termination, so under RETRIG=1 a trigger in the final
  // active cycle extends the pulse instead of ending it.
  assign accept = trig_i && (len_i != '0) &&
                  ((state_q == ST_IDLE) || (RETRIG != 0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef PULSE_STRETCH_DONE_EN
    done_d  = 1'b0;
`endif
    if (accept) begin
      state_d = ST_ACTIVE;
      cnt_d   = W'(1);
      len_d   = len_i;
    end else if (state_q == ST_ACTIVE) begin
      // Counter starts at 1 and len_q >= 1, so it never passes len_q.
      if (cnt_q == len_q) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
`ifdef PULSE_STRETCH_DONE_EN
        done_d  = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
    dout_d = (state_d == ST_ACTIVE) ? ACT_LVL : ~ACT_LVL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      dout_q  <= ~ACT_LVL;
`ifdef PULSE_STRETCH_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
`ifdef PULSE_STRETCH_DONE_EN
      done_q  <= done_d;
`endif
    end
  end

  assign dout_o      = dout_q;
  assign state_nxt_o = state_d;
`ifdef PULSE_STRETCH_DONE_EN
  assign done_o      = done_q;
`endif

endmodule

// File: rtl/pulse_stretch_mc.sv
// -----------------------------------------------------------------------------
// pulse_stretch_mc
// CH independent pulse stretchers sharing one clock and reset.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   trig     : per-channel single-cycle start request
//   len      : per-channel length, channel i at bits [i*W +: W]
//   dout     : per-channel stretched pulse (registered)
//   done     : per-channel end-of-pulse strobe (PULSE_STRETCH_DONE_EN only)
//   busy     : registered OR of all channels' active state
// Parameters: CH (1..CH_MAX), W, RETRIG, ACT_LVL.
// Optional feature macro: PULSE_STRETCH_DONE_EN
// -----------------------------------------------------------------------------
module pulse_stretch_mc
  import pulse_stretch_pkg::*;
#(
  parameter int   CH      = 4,
  parameter int   W       = 8,
  parameter int   RETRIG  = 0,
  parameter logic ACT_LVL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   trig,
  input  logic [CH*W-1:0] len,
  output logic [CH-1:0]   dout,
`ifdef PULSE_STRETCH_DONE_EN
  output logic [CH-1:0]   done,
`endif
  output logic            busy
);

  logic [CH-1:0] act_nxt;
  logic          busy_q, busy_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t st_nxt;

    pulse_stretch_ch #(
      .W      (W),
      .RETRIG (RETRIG),
      .ACT_LVL(ACT_LVL)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .trig_i     (trig[i]),
      .len_i      (len[i*W +: W]),
      .dout_o     (dout[i]),
`ifdef PULSE_STRETCH_DONE_EN
      .done_o     (done[i]),
`endif
      .state_nxt_o(st_nxt)
    );

    assign act_nxt[i] = (st_nxt == ST_ACTIVE);
  end

  // Registered from next-state so busy lines up with the registered dout.
  assign busy_d = |act_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule
